uart_tx_arbiter: RTL and testbench



---
 rtl/uart_pkg.sv | 13 +
 rtl/rr_pick.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 128 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and the arbiter state type
package uart_pkg;

  localparam int UART_BITS_N       = 8;
  localparam int UART_CLKS_PER_BIT = 50_000_000 / 115_200;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
// Returns the first set request at or after ptr, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      int cand;
      cand = (int'(ptr) + k) % N_REQ;
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-atomic round-robin arbiter in front of uart_tx
// A grant lasts from first byte to the byte flagged last, or until a fetch times out.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int BITS_N         = UART_BITS_N,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*BITS_N-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic [BITS_N-1:0]         tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy,
  output logic                      pkt_done,
  output logic                      timeout_err
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  arb_state_t        state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  grant_id_q, grant_id_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [BITS_N-1:0] hold_data_q, hold_data_d;
  logic              hold_last_q, hold_last_d;

  logic [PTR_W-1:0]  pick_idx;
  logic              pick_any;
  logic [PTR_W-1:0]  next_ptr;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign next_ptr = (grant_id_q == PTR_W'(N_REQ - 1)) ? '0 : grant_id_q + PTR_W'(1);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    tmo_cnt_d   = tmo_cnt_q;
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    pkt_done    = 1'b0;
    timeout_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        tmo_cnt_d = '0;
        if (pick_any) begin
          grant_id_d = pick_idx;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        // A byte arriving on the last allowed cycle still wins over the timeout.
        if (req_valid[grant_id_q]) begin
          hold_data_d = req_data[int'(grant_id_q)*BITS_N +: BITS_N];
          hold_last_d = req_last[grant_id_q];
          tmo_cnt_d   = '0;
          state_d     = SEND;
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout_err = 1'b1;
          rr_ptr_d    = next_ptr;
          tmo_cnt_d   = '0;
          state_d     = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (hold_last_q) begin
            pkt_done = 1'b1;
            rr_ptr_d = next_ptr;
            state_d  = IDLE;
          end else begin
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      tmo_cnt_q   <= '0;
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      tmo_cnt_q   <= tmo_cnt_d;
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == FETCH) req_ready[grant_id_q] = 1'b1;
  end

  assign tx_valid = (state_q == SEND);
  assign tx_data  = hold_data_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int TMO   = 16;
  localparam int FRAME = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [N*W-1:0] req_data;
  logic [W-1:0]   tx_data;
  logic           tx_valid, tx_ready, busy, pkt_done, timeout_err;
  logic [1:0]     grant_id;

  uart_tx_arbiter #(
    .N_REQ          (N),
    .BITS_N         (W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .pkt_done    (pkt_done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  logic [8:0] mem [N][16];
  int         head [N];
  int         tail [N];
  int         uart_cnt;
  bit         hold_low;
  logic [7:0] sent_data [$];
  logic [1:0] sent_gid [$];
  logic [1:0] done_gid [$];
  int         n_done, n_tmo, cyc, fetch_start, tmo_cyc, proto_err, stall_bad;
  bit         prev_done, prev_fetch;
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic last);
    mem[r][tail[r] & 15] = {last, d};
    tail[r]++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = (head[i] != tail[i]);
      req_data[i*W +: W] = mem[i][head[i] & 15][7:0];
      req_last[i]        = mem[i][head[i] & 15][8];
    end
    tx_ready = (uart_cnt == 0) && !hold_low;
    #1;
  endtask

  task automatic tick();
    logic [N-1:0] hs;
    logic         acc;
    @(negedge clk);
    hs  = req_valid & req_ready;
    acc = tx_valid && tx_ready;
    if (acc) begin
      sent_data.push_back(tx_data);
      sent_gid.push_back(grant_id);
    end
    if (pkt_done) begin
      n_done++;
      done_gid.push_back(grant_id);
    end
    if (timeout_err) begin
      n_tmo++;
      tmo_cyc = cyc;
    end
    if (prev_done && busy) proto_err++;
    if (pkt_done && timeout_err) proto_err++;
    if (req_ready != 0 && !prev_fetch) fetch_start = cyc;
    prev_fetch = (req_ready != 0);
    prev_done  = pkt_done;
    cyc++;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) head[i]++;
    if (acc) uart_cnt = FRAME;
    else if (uart_cnt > 0) uart_cnt--;
    drive();
  endtask

  task automatic clear_logs();
    sent_data.delete();
    sent_gid.delete();
    done_gid.delete();
    n_done = 0; n_tmo = 0; proto_err = 0; stall_bad = 0;
    fetch_start = -1; tmo_cyc = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
    uart_cnt = 0; hold_low = 1'b0;
    drive();
    tick();
    tick();
    reset = 1'b0;
    prev_done = 1'b0; prev_fetch = 1'b0;
    clear_logs();
    drive();
  endtask

  task automatic run_done(input int target, input string tag);
    int k = 0;
    while (n_done < target && k < 400) begin tick(); k++; end
    tick();
    check(tag, n_done, target);
  endtask

  task automatic wait_tx_valid(input string tag);
    int k = 0;
    while (!tx_valid && k < 50) begin tick(); k++; end
    check(tag, tx_valid, 1);
  endtask

  initial begin
    cyc = 0;
    for (int i = 0; i < N; i++) for (int j = 0; j < 16; j++) mem[i][j] = '0;
    do_reset();

    // Reset state
    check("rst_req_ready", req_ready, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_grant_id", grant_id, 0);

    // Requester 0, three-byte packet, with latency checks
    push(0, 8'h41, 0); push(0, 8'h42, 0); push(0, 8'h43, 1);
    drive();
    check("lat_c0_req_ready", req_ready, 0);
    tick();
    check("lat_c1_req_ready", req_ready, 4'b0001);
    check("lat_c1_busy", busy, 1);
    check("lat_c1_tx_valid", tx_valid, 0);
    tick();
    check("lat_c2_tx_valid", tx_valid, 1);
    check("lat_c2_tx_data", tx_data, 8'h41);
    check("lat_c2_req_ready", req_ready, 0);
    run_done(1, "p0_done_count");
    check("p0_nbytes", sent_data.size(), 3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("p0_byte%0d", k), sent_data[k], 8'h41 + k);
      check($sformatf("p0_gid%0d", k), sent_gid[k], 0);
    end
    check("p0_busy_end", busy, 0);

    // Requesters 1 and 2 contend in the same cycle
    do_reset();
    push(1, 8'h11, 0); push(1, 8'h12, 1);
    push(2, 8'h21, 0); push(2, 8'h22, 1);
    drive();
    run_done(2, "p12_done_count");
    check("p12_nbytes", sent_data.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("p12_byte%0d", k), sent_data[k], (k < 2) ? (8'h11 + k) : (8'h21 + k - 2));
      check($sformatf("p12_gid%0d", k), sent_gid[k], (k < 2) ? 1 : 2);
    end
    check("p12_rr_ptr", 32'(dut.rr_ptr_q), 3);
    check("p12_proto", proto_err, 0);

    // All four requesters continuously valid for 8 one-byte packets
    do_reset();
    for (int p = 0; p < 2; p++) for (int r = 0; r < N; r++) push(r, 8'((r << 4) | p), 1);
    drive();
    run_done(8, "rr8_done_count");
    check("rr8_nbytes", sent_data.size(), 8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rr8_gid%0d", k), done_gid[k], k % 4);
      check($sformatf("rr8_byte%0d", k), sent_data[k], ((k % 4) << 4) | (k / 4));
    end
    check("rr8_idle_gap", proto_err, 0);

    // Requester 3 stalls mid-packet and loses its grant
    do_reset();
    push(3, 8'h33, 0);
    drive();
    begin
      int k = 0;
      while (n_tmo == 0 && k < 200) begin tick(); k++; end
    end
    check("tmo_count", n_tmo, 1);
    check("tmo_offset", tmo_cyc - fetch_start, TMO - 1);
    tick();
    check("tmo_busy", busy, 0);
    check("tmo_rr_ptr", 32'(dut.rr_ptr_q), 0);
    check("tmo_nbytes", sent_data.size(), 1);
    check("tmo_no_done", n_done, 0);

    // tx_ready held low for 100 cycles while in SEND
    do_reset();
    hold_low = 1'b1;
    push(2, 8'h55, 0); push(2, 8'h56, 1);
    drive();
    wait_tx_valid("stall_reach_send");
    for (int k = 0; k < 100; k++) begin
      tick();
      if (!tx_valid || tx_data != 8'h55 || req_ready != 0 || timeout_err) stall_bad++;
    end
    check("stall_stable", stall_bad, 0);
    check("stall_no_tmo", n_tmo, 0);
    hold_low = 1'b0;
    drive();
    run_done(1, "stall_done_count");
    check("stall_nbytes", sent_data.size(), 2);
    check("stall_byte1", sent_data[1], 8'h56);

    // Reset while a byte is held in SEND
    do_reset();
    hold_low = 1'b1;
    push(1, 8'h61, 0); push(1, 8'h62, 1);
    drive();
    wait_tx_valid("mid_reach_send");
    reset = 1'b1;
    drive();
    tick();
    check("mid_tx_valid", tx_valid, 0);
    check("mid_tx_data", tx_data, 0);
    check("mid_req_ready", req_ready, 0);
    check("mid_busy", busy, 0);
    check("mid_pulses", {pkt_done, timeout_err}, 0);
    check("mid_grant_id", grant_id, 0);
    reset = 1'b0;
    head[1] = tail[1];
    hold_low = 1'b0;
    clear_logs();
    push(0, 8'h70, 1); push(2, 8'h72, 1);
    drive();
    tick();
    check("mid_regrant_ready", req_ready, 4'b0001);
    check("mid_regrant_gid", grant_id, 0);
    run_done(2, "mid_done_count");
    check("mid_byte0", sent_data[0], 8'h70);
    check("mid_byte1", sent_data[1], 8'h72);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
